// File: rtl/rr_arbiter_pkg.sv
// Shared types and widths for the 4-requester round-robin arbiter.
// No logic lives here; latency not applicable.
// No backpressure; definitions only.
package rr_arbiter_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 8;

endpackage

// File: rtl/rr_pick_4.sv
// Rotated priority encoder: first set req bit scanning ptr, ptr+1, ... mod 4.
// Purely combinational, zero latency.
// No backpressure; any=0 means nothing to pick and idx is don't-care (returns ptr).
module rr_pick_4
  import rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit to ptr wins last.
  always_comb begin
    any  = |req;
    idx  = ptr;
    cand = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold, release handshake and hold timeout.
// Latency: req to grant_valid is one cycle; every grant is followed by a one-cycle idle bubble.
// Backpressure: none; the owner ends its grant with release_pulse or by dropping req, else MAX_HOLD revokes it.
module rr_arbiter_4
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N_REQ-1:0] req,
  // Owner's end-of-grant pulse ("release" itself is a reserved word).
  input  logic             release_pulse,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout
);

  // Value of hold_cnt on the last cycle a grant may be held; unused when MAX_HOLD is 0.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_done;
  logic             hold_expired;
  logic [IDX_W-1:0] ptr_after;

  rr_pick_4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Grant-ending conditions and the rotated pointer used after a normal or timed-out end.
  always_comb begin
    owner_done   = release_pulse || !req[grant_idx];
    hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    ptr_after    = grant_idx + IDX_W'(1);
  end

  // Arbitration FSM; all outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ena && pick_any) begin
            state       <= S_GRANT;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            grant_valid <= 1'b0;
          end
        end
        S_GRANT: begin
          if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          // Disable wins: the owner keeps its turn, so ptr stays put.
          if (!ena) begin
            state       <= S_IDLE;
            grant_valid <= 1'b0;
          end else if (owner_done) begin
            // A release coinciding with the hold limit is a clean release, no timeout.
            state       <= S_IDLE;
            grant_valid <= 1'b0;
            ptr         <= ptr_after;
          end else if (hold_expired) begin
            state       <= S_IDLE;
            grant_valid <= 1'b0;
            ptr         <= ptr_after;
            timeout     <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
